// File: rtl/signed_subtractor_pipe.sv
// signed_subtractor_pipe
//   Two-stage valid/ready pipeline computing the saturated two's-complement
//   difference a - b. It also tracks saturation events with sticky flags and a
//   saturating event counter.
//
// Ports
//   clk        : clock, rising-edge active
//   rst_n      : asynchronous active-low reset
//   in_valid   : operands a/b are presented
//   in_ready   : block accepts operands this cycle (combinational from out_ready)
//   a, b       : signed minuend / subtrahend, N bits
//   out_valid  : result presented on diff/ov/uv
//   out_ready  : downstream accepts the result
//   diff       : saturated a - b, N bits
//   ov, uv     : current result saturated positive / negative
//   ov_sticky  : latched positive saturation
//   uv_sticky  : latched negative saturation
//   sat_cnt    : number of saturated results loaded into stage 2 (saturating)
//   sat_clr    : synchronous clear of sticky flags and sat_cnt
module signed_subtractor_pipe #(
    parameter int N  = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  diff,
    output logic          ov,
    output logic          uv,
    output logic          ov_sticky,
    output logic          uv_sticky,
    output logic [CW-1:0] sat_cnt,
    input  logic          sat_clr
);

    localparam logic [N-1:0]  MAX_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]  MIN_NEG = {1'b1, {(N-1){1'b0}}};
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic          s1_valid;
    logic [N-1:0]  s1_a;
    logic [N-1:0]  s1_b;
    logic          s1_en;
    logic          s2_en;
    logic [N:0]    ext;
    logic          ext_ov;
    logic          ext_uv;
    logic [N-1:0]  sat_diff;
    logic          sat_load;

    assign s2_en    = !out_valid || out_ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en;

    // One guard bit is enough: the two top bits disagree exactly when the
    // true difference falls outside the N-bit signed range.
    always_comb begin
        ext      = {s1_a[N-1], s1_a} - {s1_b[N-1], s1_b};
        ext_ov   = !ext[N] &&  ext[N-1];
        ext_uv   =  ext[N] && !ext[N-1];
        sat_diff = ext[N-1:0];
        if (ext_ov) begin
            sat_diff = MAX_POS;
        end else if (ext_uv) begin
            sat_diff = MIN_NEG;
        end
    end

    assign sat_load = s2_en && s1_valid && (ext_ov || ext_uv);

    // Stage 1: operand capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a <= a;
                s1_b <= b;
            end
        end
    end

    // Stage 2: result register; data only updates on a real result so a
    // bubble never disturbs the last presented value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            diff      <= '0;
            ov        <= 1'b0;
            uv        <= 1'b0;
        end else if (s2_en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                diff <= sat_diff;
                ov   <= ext_ov;
                uv   <= ext_uv;
            end
        end
    end

    // Saturation bookkeeping; a clear coinciding with a saturated load
    // still records that load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_sticky <= 1'b0;
            uv_sticky <= 1'b0;
            sat_cnt   <= '0;
        end else if (sat_clr) begin
            ov_sticky <= s2_en && s1_valid && ext_ov;
            uv_sticky <= s2_en && s1_valid && ext_uv;
            sat_cnt   <= sat_load ? CNT_ONE : '0;
        end else begin
            if (s2_en && s1_valid && ext_ov) ov_sticky <= 1'b1;
            if (s2_en && s1_valid && ext_uv) uv_sticky <= 1'b1;
            if (sat_load && (sat_cnt != '1)) sat_cnt <= sat_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_signed_subtractor_pipe.sv
module tb_signed_subtractor_pipe;

    typedef struct packed {
        logic [7:0] d;
        logic       o;
        logic       u;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  diff;
    logic        ov;
    logic        uv;
    logic        ov_sticky;
    logic        uv_sticky;
    logic [15:0] sat_cnt;
    logic        sat_clr;

    // Second instance with a tiny counter to reach counter saturation quickly
    logic        in_valid2;
    logic        in_ready2;
    logic [7:0]  a2;
    logic [7:0]  b2;
    logic        out_valid2;
    logic [7:0]  diff2;
    logic        ov2;
    logic        uv2;
    logic        ov_sticky2;
    logic        uv_sticky2;
    logic [2:0]  sat_cnt2;

    int   checks   = 0;
    int   failures = 0;
    int   accepted = 0;
    int   cyc      = 0;
    exp_t sb[$];

    signed_subtractor_pipe #(.N(8), .CW(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .ov(ov), .uv(uv), .ov_sticky(ov_sticky),
        .uv_sticky(uv_sticky), .sat_cnt(sat_cnt), .sat_clr(sat_clr)
    );

    signed_subtractor_pipe #(.N(8), .CW(3)) dut_small (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .out_valid(out_valid2), .out_ready(1'b1),
        .diff(diff2), .ov(ov2), .uv(uv2), .ov_sticky(ov_sticky2),
        .uv_sticky(uv_sticky2), .sat_cnt(sat_cnt2), .sat_clr(1'b0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: compare the presented result with the scoreboard head every
    // cycle it is valid (covers stability while stalled); pop on transfer.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got diff=%0h with empty scoreboard", diff);
            end else begin
                chk("result", {22'd0, diff, ov, uv}, {22'd0, sb[0].d, sb[0].o, sb[0].u});
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic send(input int av, input int bv, input int ed, input logic eo, input logic eu);
        int unsigned w;
        exp_t e;
        w = 0;
        a = 8'(av);
        b = 8'(bv);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            w++;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
        end else begin
            e.d = 8'(ed);
            e.o = eo;
            e.u = eu;
            sb.push_back(e);
            accepted++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        int t0;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1; sat_clr = 1'b0;
        in_valid2 = 1'b0; a2 = '0; b2 = '0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_diff_flags", {22'd0, diff, ov, uv}, 32'd0);
        chk("rst_sat_cnt", {16'd0, sat_cnt}, 32'd0);
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // Positive saturation, latency 2
        send(100, -50, 127, 1'b1, 1'b0);
        chk("lat_not_yet", 32'(out_valid), 32'd0);
        idle(1);
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("ov_sticky_set", 32'(ov_sticky), 32'd1);
        chk("sat_cnt_1", {16'd0, sat_cnt}, 32'd1);
        idle(2);

        // Negative saturation, normal, extreme-equal operands
        send(-100, 50, -128, 1'b0, 1'b1);
        idle(1);
        chk("uv_sticky_set", 32'(uv_sticky), 32'd1);
        send(20, 30, -10, 1'b0, 1'b0);
        send(-128, -128, 0, 1'b0, 1'b0);
        idle(4);

        // Throughput: four back-to-back accepts in four cycles
        t0 = cyc;
        send(127, 127, 0, 1'b0, 1'b0);
        send(-128, 127, -128, 1'b0, 1'b1);
        send(0, -128, 127, 1'b1, 1'b0);
        send(10, -5, 15, 1'b0, 1'b0);
        chk("throughput_cycles", 32'(cyc - t0), 32'd4);
        idle(4);

        // Backpressure
        out_ready = 1'b0;
        accepted = 0;
        fork
            begin
                send(127, -1, 127, 1'b1, 1'b0);
                send(-128, 1, -128, 1'b0, 1'b1);
                send(50, 20, 30, 1'b0, 1'b0);
                send(-1, -1, 0, 1'b0, 1'b0);
            end
            begin
                idle(6);
                chk("bp_in_ready_low", 32'(in_ready), 32'd0);
                chk("bp_accepts", 32'(accepted), 32'd2);
                chk("bp_head_held", {24'd0, diff}, 32'h7F);
                out_ready = 1'b1;
            end
        join
        idle(5);
        chk("bp_drained", 32'(sb.size()), 32'd0);
        chk("sat_cnt_6", {16'd0, sat_cnt}, 32'd6);

        // sat_clr coinciding with a saturated stage-2 load
        send(100, -50, 127, 1'b1, 1'b0);
        sat_clr = 1'b1;
        idle(1);
        sat_clr = 1'b0;
        chk("clr_load_ov_sticky", 32'(ov_sticky), 32'd1);
        chk("clr_load_uv_sticky", 32'(uv_sticky), 32'd0);
        chk("clr_load_sat_cnt", {16'd0, sat_cnt}, 32'd1);
        idle(2);
        sat_clr = 1'b1;
        idle(1);
        sat_clr = 1'b0;
        chk("clr_alone_flags", {30'd0, ov_sticky, uv_sticky}, 32'd0);
        chk("clr_alone_sat_cnt", {16'd0, sat_cnt}, 32'd0);

        // Reset with two results in flight
        out_ready = 1'b0;
        send(-100, 50, -128, 1'b0, 1'b1);
        send(20, 30, -10, 1'b0, 1'b0);
        chk("pre_rst_sat_cnt", {16'd0, sat_cnt}, 32'd1);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_sat_cnt", {16'd0, sat_cnt}, 32'd0);
        chk("mid_rst_sticky", {30'd0, ov_sticky, uv_sticky}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(3);
        chk("post_rst_idle", 32'(out_valid), 32'd0);
        send(50, 20, 30, 1'b0, 1'b0);
        idle(4);
        chk("post_rst_drained", 32'(sb.size()), 32'd0);

        // Counter saturation on the CW=3 instance: 9 saturated loads -> 7
        a2 = 8'd100;
        b2 = 8'hCE;
        in_valid2 = 1'b1;
        idle(9);
        in_valid2 = 1'b0;
        idle(3);
        chk("cnt_saturates", 32'(sat_cnt2), 32'd7);
        chk("cnt_sticky_small", 32'(ov_sticky2), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
